// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port round-robin front end for a 1-cycle SRAM.
// All SRAM controls are registered; locked bursts are capped at LOCK_MAX.
module sram_port_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic          LOCK0,
  input  logic          LOCK1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WD0,
  input  logic [DW-1:0] WD1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RV0,
  output logic          RV1,
  output logic [DW-1:0] RDATA,
  output logic          SRAM_CEN,
  output logic          SRAM_WEN,
  output logic [AW-1:0] SRAM_A,
  output logic [DW-1:0] SRAM_D,
  input  logic [DW-1:0] SRAM_Q
);

  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] LIM = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic any, both, keep0, keep1, hold, sel1, stay;

  assign RDATA = SRAM_Q;

  // Pick the winner and update ownership and the lock run counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    sel1    = 1'b0;
    any     = REQ0 | REQ1;
    both    = REQ0 & REQ1;
    keep0   = (state_q == OWN0) && LOCK0 && (cnt_q < LIM);
    keep1   = (state_q == OWN1) && LOCK1 && (cnt_q < LIM);
    hold    = both && (keep0 || keep1);
    unique case (1'b1)
      !any:                     sel1 = 1'b0;
      REQ0 && !REQ1:            sel1 = 1'b0;
      !REQ0 && REQ1:            sel1 = 1'b1;
      both && keep0:            sel1 = 1'b0;
      both && keep1:            sel1 = 1'b1;
      both && !keep0 && !keep1: sel1 = ~last_q;
      default:                  sel1 = 1'b0;
    endcase
    stay = ((state_q == OWN0) && !sel1 && LOCK0) ||
           ((state_q == OWN1) &&  sel1 && LOCK1);
    if (!any) begin
      state_d = IDLE;
    end else begin
      state_d = sel1 ? OWN1 : OWN0;
      last_d  = sel1;
    end
    if (hold)
      cnt_d = cnt_q + CW'(1);
    else if (any && stay)
      cnt_d = cnt_q;
    else
      cnt_d = '0;
  end

  // Arbitration state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered SRAM controls, grant pulses and read-valid strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SRAM_CEN <= 1'b1;
      SRAM_WEN <= 1'b1;
      SRAM_A   <= '0;
      SRAM_D   <= '0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      RV0      <= 1'b0;
      RV1      <= 1'b0;
    end else begin
      RV0 <= GNT0 & SRAM_WEN;
      RV1 <= GNT1 & SRAM_WEN;
      if (any) begin
        SRAM_CEN <= 1'b0;
        SRAM_WEN <= sel1 ? ~WE1 : ~WE0;
        SRAM_A   <= sel1 ? ADDR1 : ADDR0;
        SRAM_D   <= sel1 ? WD1 : WD0;
        GNT0     <= ~sel1;
        GNT1     <= sel1;
      end else begin
        SRAM_CEN <= 1'b1;
        SRAM_WEN <= 1'b1;
        GNT0     <= 1'b0;
        GNT1     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed tests with a behavioural arbiter model
// and an SRAM model; every cycle is compared at the falling edge.
module tb_sram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LM = 4;

  logic clk, rst_n;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rdata;
  logic cen, wen;
  logic [AW-1:0] sa;
  logic [DW-1:0] sd, sq;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  sram_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .LOCK0(lock0), .LOCK1(lock1),
    .ADDR0(addr0), .ADDR1(addr1), .WD0(wd0), .WD1(wd1),
    .GNT0(gnt0), .GNT1(gnt1), .RV0(rv0), .RV1(rv1),
    .RDATA(rdata), .SRAM_CEN(cen), .SRAM_WEN(wen),
    .SRAM_A(sa), .SRAM_D(sd), .SRAM_Q(sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM array and its reference copy start with the same pattern.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] gold [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]  = DW'(i * 3 + 1);
      gold[i] = DW'(i * 3 + 1);
    end
    sq = '0;
  end

  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[sa] <= sd;
      else      sq <= mem[sa];
    end
  end

  // Reference model: who owns the SRAM, how long it has held it
  // under contention, and what each output must show next cycle.
  logic e_g0, e_g1, e_rv0, e_rv1, e_cen, e_wen, e_rd;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d, e_q, e_rdq;
  int m_owner, m_last, m_run, w;
  logic lk, wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0;
      e_cen = 1; e_wen = 1; e_a = '0; e_d = '0; e_rd = 0;
      e_q = '0; e_rdq = '0;
      m_owner = -1; m_last = 1; m_run = 0;
    end else begin
      e_rv0 = e_g0 && e_rd;
      e_rv1 = e_g1 && e_rd;
      e_q = e_rdq;
      if (!req0 && !req1) begin
        e_g0 = 0; e_g1 = 0; e_cen = 1; e_wen = 1; e_rd = 0;
        m_owner = -1; m_run = 0;
      end else begin
        lk = (m_owner == 0) ? lock0 : (m_owner == 1) ? lock1 : 1'b0;
        if (req0 && req1) begin
          if (lk && m_run < LM) begin
            w = m_owner;
            m_run++;
          end else begin
            w = 1 - m_last;
            m_run = 1;
          end
        end else begin
          w = req0 ? 0 : 1;
          if (!(w == m_owner && lk)) m_run = 1;
        end
        wr = (w == 1) ? we1 : we0;
        e_g0 = (w == 0);
        e_g1 = (w == 1);
        e_cen = 0;
        e_wen = !wr;
        e_rd = !wr;
        e_a = (w == 1) ? addr1 : addr0;
        e_d = (w == 1) ? wd1 : wd0;
        if (wr) gold[e_a] = e_d;
        else    e_rdq = gold[e_a];
        m_owner = w;
        m_last = w;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt0", 32'(gnt0), 32'(e_g0));
      chk("gnt1", 32'(gnt1), 32'(e_g1));
      chk("rv0", 32'(rv0), 32'(e_rv0));
      chk("rv1", 32'(rv1), 32'(e_rv1));
      chk("cen", 32'(cen), 32'(e_cen));
      chk("wen", 32'(wen), 32'(e_wen));
      chk("addr", 32'(sa), 32'(e_a));
      chk("wdat", 32'(sd), 32'(e_d));
      if (e_rv0 || e_rv1) chk("rdata", 32'(rdata), 32'(e_q));
    end
  end

  logic [3:0] seq4;
  logic [8:0] seq9;
  int n;

  initial begin
    rst_n = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("rst_cen", 32'(cen), 32'd1);
    chk("rst_wen", 32'(wen), 32'd1);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_rv", 32'({rv0, rv1}), 32'd0);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("idle_cen", 32'(cen), 32'd1);
    chk("idle_a", 32'(sa), 32'd0);
    chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);

    // Port 0 write, port 1 read back.
    req0 = 1; we0 = 1; addr0 = 9'h1A5; wd0 = 8'h3C;
    @(negedge clk);
    chk("t2_gnt0", 32'(gnt0), 32'd1);
    chk("t2_wen", 32'(wen), 32'd0);
    chk("t2_a", 32'(sa), 32'h1A5);
    chk("t2_d", 32'(sd), 32'h3C);
    req0 = 0; we0 = 0;
    req1 = 1; we1 = 0; addr1 = 9'h1A5;
    @(negedge clk);
    chk("t2_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    @(negedge clk);
    chk("t2_rv1", 32'(rv1), 32'd1);
    chk("t2_rv0", 32'(rv0), 32'd0);
    chk("t2_rdata", 32'(rdata), 32'h3C);
    repeat (2) @(negedge clk);

    // Contested unlocked reads alternate.
    addr0 = 9'h010; addr1 = 9'h011; req0 = 1; req1 = 1;
    seq4 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq4 = {seq4[2:0], gnt1};
    end
    req0 = 0; req1 = 0;
    chk("t3_seq", 32'(seq4), 32'b0101);
    repeat (3) @(negedge clk);

    // Locked port 0 against port 1, capped at LM grants.
    addr0 = 9'h020; addr1 = 9'h021; lock0 = 1; req0 = 1; req1 = 1;
    seq9 = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seq9 = {seq9[7:0], gnt1};
    end
    req0 = 0; req1 = 0; lock0 = 0;
    chk("t4_seq", 32'(seq9), 32'b000010000);
    repeat (3) @(negedge clk);

    // Write burst on port 0, then read it back on port 1.
    we0 = 1; addr0 = '0; wd0 = 8'd3; req0 = 1; n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gnt0) n++;
      addr0 = AW'(i + 1);
      wd0 = DW'((i + 1) * 7 + 3);
      if (i == 15) req0 = 0;
    end
    we0 = 0;
    chk("t5_wr_gnts", 32'(n), 32'd16);
    req1 = 1; we1 = 0; addr1 = '0; n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rv1) n++;
      if (i < 15) addr1 = AW'(i + 1);
      else req1 = 0;
    end
    @(negedge clk);
    if (rv1) n++;
    chk("t5_last_rd", 32'(rdata), 32'h6C);
    chk("t5_rv_cnt", 32'(n), 32'd16);
    repeat (2) @(negedge clk);

    // Top address passes through unchanged.
    req1 = 1; we1 = 1; addr1 = 9'h1FF; wd1 = 8'h99;
    @(negedge clk);
    chk("top_a", 32'(sa), 32'h1FF);
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 9'h1FF;
    @(negedge clk);
    chk("top_gnt0", 32'(gnt0), 32'd1);
    req0 = 0;
    @(negedge clk);
    chk("top_rv0", 32'(rv0), 32'd1);
    chk("top_rd", 32'(rdata), 32'h99);
    repeat (2) @(negedge clk);

    // Reset while a read is in flight.
    req1 = 1; we1 = 0; addr1 = 9'h1FF;
    @(negedge clk);
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_cen", 32'(cen), 32'd1);
    chk("t6_gnt1_clr", 32'(gnt1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv1) n++;
    end
    chk("t6_no_rv", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
